// File: rtl/npc_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared types and constants for the NPC multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    // Sequencer states; the encoding is reused by the control FSM.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } npc_state_e;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    localparam logic [31:0] NPC_EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] NPC_RESET_PC    = 32'h8000_0000;

    // A redirect target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl_fsm_if
// Description : Instruction-memory request/response handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_ctrl_fsm_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;

    // Core side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_inst
    );

    // Memory side.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_inst
    );

endinterface : npc_ctrl_fsm_if
`default_nettype wire

// File: rtl/npc_ctrl_fsm_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module      : npc_fetch_timer
// Description : 8-bit WAIT-state timeout counter with clear and enable.
//               expire is high while the count equals TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_fetch_timer #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  wire logic clk,
    input  wire logic rst,      // synchronous, active low
    input  wire logic clr,
    input  wire logic en,
    output logic      expire
);

    logic [7:0] r_count;

    // Count waiting cycles; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else if (clr) begin
            r_count <= 8'd0;
        end else if (en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expire = (r_count == TIMEOUT);

endmodule : npc_fetch_timer
`default_nettype wire

// File: rtl/npc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : npc_ctrl_fsm
// Description : Multi-cycle NPC sequencer. Owns the PC, fetches over a
//               valid/ready handshake, latches the IR, gates the register
//               file write to EXEC, halts on ebreak, stops on errors.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_ctrl_fsm
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = NPC_RESET_PC,
    parameter logic [31:0] EBREAK_INST = NPC_EBREAK_INST,
    parameter logic [7:0]  TIMEOUT     = 8'd255
) (
    input  wire logic           clk,
    input  wire logic           rst,        // synchronous, active low
    npc_ctrl_fsm_if.master      imem,
    output logic [31:0]         inst,
    input  wire logic           dec_reg_wen,
    output logic                rf_wen,
    input  wire logic           br_taken,
    input  wire logic [31:0]    br_target,
    output logic [31:0]         pc,
    output logic                halt,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [31:0]         instret
);

    localparam logic [2:0] c_IDLE  = ST_IDLE;
    localparam logic [2:0] c_FETCH = ST_FETCH;
    localparam logic [2:0] c_WAIT  = ST_WAIT;
    localparam logic [2:0] c_EXEC  = ST_EXEC;
    localparam logic [2:0] c_HALT  = ST_HALT;
    localparam logic [2:0] c_ERR   = ST_ERR;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [1:0]  r_err_code;
    logic [31:0] r_instret;

    logic        w_in_fetch;
    logic        w_in_wait;
    logic        w_in_exec;
    logic        w_accept;
    logic        w_is_ebreak;
    logic        w_misalign;
    logic        w_expire;
    logic        w_timer_en;
    logic [31:0] w_pc_next;

    assign w_in_fetch  = (r_state == c_FETCH);
    assign w_in_wait   = (r_state == c_WAIT);
    assign w_in_exec   = (r_state == c_EXEC);
    assign w_accept    = w_in_fetch && imem.imem_req_ready;
    assign w_is_ebreak = (r_inst == EBREAK_INST);
    assign w_misalign  = br_taken && is_misaligned(br_target);
    assign w_pc_next   = br_taken ? br_target : (r_pc + 32'd4);
    assign w_timer_en  = w_in_wait && !imem.imem_resp_valid;

    npc_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_timer_en),
        .expire (w_expire)
    );

    // Sequencer state, PC, IR, retire counter and error code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_err_code <= ERR_NONE;
            r_instret  <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    if (imem.imem_req_ready) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        r_inst  <= imem.imem_resp_inst;
                        r_state <= c_EXEC;
                    end else if (w_expire) begin
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= c_ERR;
                    end
                end
                c_EXEC: begin
                    if (w_is_ebreak) begin
                        r_instret <= r_instret + 32'd1;
                        r_state   <= c_HALT;
                    end else if (w_misalign) begin
                        r_err_code <= ERR_MISALIGN;
                        r_state    <= c_ERR;
                    end else begin
                        r_pc      <= w_pc_next;
                        r_instret <= r_instret + 32'd1;
                        r_state   <= c_FETCH;
                    end
                end
                c_HALT, c_ERR: begin
                    // Terminal until reset; everything holds.
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req_valid = w_in_fetch;
    assign imem.imem_req_addr  = r_pc;

    // Write is suppressed for the ebreak and misaligned-redirect cases.
    assign rf_wen   = w_in_exec && dec_reg_wen && !w_is_ebreak && !w_misalign;
    assign inst     = r_inst;
    assign pc       = r_pc;
    assign halt     = (r_state == c_HALT);
    assign err      = (r_state == c_ERR);
    assign err_code = r_err_code;
    assign instret  = r_instret;

endmodule : npc_ctrl_fsm
`default_nettype wire

// File: tb/tb_npc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_ctrl_fsm
// Description : Self-checking bench for npc_ctrl_fsm with a transaction-level
//               reference model (expected PC / retire count per instruction).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_ctrl_fsm;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_reg_wen = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic [31:0] inst;
    logic        rf_wen;
    logic [31:0] pc;
    logic        halt;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] instret;

    npc_ctrl_fsm_if imem_if ();

    npc_ctrl_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_if),
        .inst        (inst),
        .dec_reg_wen (dec_reg_wen),
        .rf_wen      (rf_wen),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .halt        (halt),
        .err         (err),
        .err_code    (err_code),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rf_cnt = 0;
    int          g_req_cyc = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instret = 32'd0;

    // Count register-file write pulses mid-cycle.
    always @(negedge clk) if (rf_wen === 1'b1) rf_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_inst  = 32'd0;
        dec_reg_wen = 1'b0;
        br_taken    = 1'b0;
        repeat (n) step();
        rst = 1'b1;
        m_pc      = RST_PC;
        m_instret = 32'd0;
    endtask

    // One instruction through the handshake, checked against the model.
    task automatic run_instr(input logic [31:0] ins, input logic wen, input logic br,
                             input logic [31:0] tgt, input int rdly, input int pdly);
        int  n;
        logic exp_wen;
        n = 0;
        while (imem_if.imem_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== m_pc) begin
            errors++;
            $display("FAIL req_issue: valid=%b addr=%h, want valid=1 addr=%h",
                     imem_if.imem_req_valid, imem_if.imem_req_addr, m_pc);
        end
        g_req_cyc = cyc;
        for (int i = 0; i < rdly; i++) begin
            imem_if.imem_req_ready = 1'b0;
            step();
            checks++;
            if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== m_pc ||
                pc !== m_pc || instret !== m_instret) begin
                errors++;
                $display("FAIL req_hold: valid=%b addr=%h pc=%h instret=%0d, want 1/%h/%h/%0d",
                         imem_if.imem_req_valid, imem_if.imem_req_addr, pc, instret,
                         m_pc, m_pc, m_instret);
            end
        end
        // Accept cycle; a simultaneous response must be ignored.
        imem_if.imem_req_ready  = 1'b1;
        imem_if.imem_resp_valid = 1'($urandom_range(0, 1));
        imem_if.imem_resp_inst  = ~ins;
        step();
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        checks++;
        if (imem_if.imem_req_valid !== 1'b0 || (cyc - g_req_cyc) != rdly + 1) begin
            errors++;
            $display("FAIL wait_entry: valid=%b after %0d cycles, want valid=0 after %0d",
                     imem_if.imem_req_valid, cyc - g_req_cyc, rdly + 1);
        end
        for (int i = 0; i < pdly; i++) begin
            step();
            checks++;
            if (imem_if.imem_req_valid !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL wait_idle: valid=%b err=%b, want 0/0", imem_if.imem_req_valid, err);
            end
        end
        imem_if.imem_resp_valid = 1'b1;
        imem_if.imem_resp_inst  = ins;
        step();
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_inst  = $urandom;
        dec_reg_wen = wen;
        br_taken    = br;
        br_target   = tgt;
        #1;
        exp_wen = wen && (ins != EBRK) && !(br && tgt[1:0] != 2'b00);
        checks++;
        if (inst !== ins || rf_wen !== exp_wen || pc !== m_pc) begin
            errors++;
            $display("FAIL exec: inst=%h rf_wen=%b pc=%h, want %h/%b/%h",
                     inst, rf_wen, pc, ins, exp_wen, m_pc);
        end
        step();
        dec_reg_wen = 1'b0;
        br_taken    = 1'b0;
        if (ins == EBRK) begin
            m_instret++;
            checks++;
            if (halt !== 1'b1 || err !== 1'b0 || pc !== m_pc || instret !== m_instret ||
                imem_if.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL ebreak: halt=%b err=%b pc=%h instret=%0d valid=%b, want 1/0/%h/%0d/0",
                         halt, err, pc, instret, imem_if.imem_req_valid, m_pc, m_instret);
            end
        end else if (br && tgt[1:0] != 2'b00) begin
            checks++;
            if (err !== 1'b1 || err_code !== 2'd2 || pc !== m_pc || instret !== m_instret ||
                imem_if.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign: err=%b code=%0d pc=%h instret=%0d valid=%b, want 1/2/%h/%0d/0",
                         err, err_code, pc, instret, imem_if.imem_req_valid, m_pc, m_instret);
            end
        end else begin
            m_pc      = br ? tgt : m_pc + 32'd4;
            m_instret = m_instret + 32'd1;
            checks++;
            if (pc !== m_pc || instret !== m_instret || imem_if.imem_req_valid !== 1'b1 ||
                imem_if.imem_req_addr !== m_pc || halt !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL retire: pc=%h instret=%0d valid=%b addr=%h, want %h/%0d/1/%h",
                         pc, instret, imem_if.imem_req_valid, imem_if.imem_req_addr,
                         m_pc, m_instret, m_pc);
            end
        end
    endtask

    // Poke the stopped core with traffic and confirm nothing moves.
    task automatic test_stopped(input logic exp_halt, input logic [1:0] exp_code);
        logic [31:0] s_inst;
        s_inst = inst;
        for (int i = 0; i < 12; i++) begin
            imem_if.imem_req_ready  = 1'($urandom_range(0, 1));
            imem_if.imem_resp_valid = 1'($urandom_range(0, 1));
            imem_if.imem_resp_inst  = $urandom;
            dec_reg_wen = 1'b1;
            br_taken    = 1'($urandom_range(0, 1));
            br_target   = $urandom;
            #1;
            checks++;
            if (halt !== exp_halt || err !== !exp_halt || err_code !== exp_code ||
                pc !== m_pc || inst !== s_inst || instret !== m_instret ||
                rf_wen !== 1'b0 || imem_if.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stopped: halt=%b err=%b code=%0d pc=%h inst=%h instret=%0d rf_wen=%b valid=%b, want %b/%b/%0d/%h/%h/%0d/0/0",
                         halt, err, err_code, pc, inst, instret, rf_wen, imem_if.imem_req_valid,
                         exp_halt, !exp_halt, exp_code, m_pc, s_inst, m_instret);
            end
            step();
        end
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        dec_reg_wen = 1'b0;
        br_taken    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (pc !== RST_PC || inst !== 32'd0 || imem_if.imem_req_valid !== 1'b0 ||
            rf_wen !== 1'b0 || halt !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 ||
            instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: pc=%h inst=%h valid=%b rf_wen=%b halt=%b err=%b code=%0d instret=%0d",
                     pc, inst, imem_if.imem_req_valid, rf_wen, halt, err, err_code, instret);
        end
        step();
        checks++;
        if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: valid=%b addr=%h, want 1/%h",
                     imem_if.imem_req_valid, imem_if.imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_three_addi();
        int rf0;
        int prev;
        rf0  = rf_cnt;
        prev = -1;
        for (int i = 0; i < 3; i++) begin
            run_instr(ADDI, 1'b1, 1'b0, 32'd0, 0, 0);
            if (prev >= 0) begin
                checks++;
                if (g_req_cyc - prev != 3) begin
                    errors++;
                    $display("FAIL req_spacing: %0d cycles, want 3", g_req_cyc - prev);
                end
            end
            prev = g_req_cyc;
        end
        checks++;
        if (instret !== 32'd3 || rf_cnt - rf0 != 3) begin
            errors++;
            $display("FAIL three_addi: instret=%0d rf_pulses=%0d, want 3/3", instret, rf_cnt - rf0);
        end
    endtask

    task automatic test_ready_stall();
        run_instr(ADDI, 1'b1, 1'b0, 32'd0, 5, 0);
    endtask

    task automatic test_wrap();
        run_instr(ADDI, 1'b0, 1'b1, 32'hFFFF_FFFC, 0, 1);
        run_instr(ADDI, 1'b1, 1'b0, 32'd0, 1, 0);
        checks++;
        if (pc !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h err=%b, want 00000000/0", pc, err);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [31:0] tmp;
        int rf0;
        int exp_rf;
        rf0 = rf_cnt;
        exp_rf = 0;
        for (int k = 0; k < 40; k++) begin
            ins = $urandom;
            if (ins == EBRK) ins = ins ^ 32'd1;
            tmp = $urandom;
            begin
                logic w;
                logic b;
                w = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 3) == 0);
                if (w) exp_rf++;
                run_instr(ins, w, b, {tmp[31:2], 2'b00},
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            end
        end
        checks++;
        if (rf_cnt - rf0 != exp_rf) begin
            errors++;
            $display("FAIL random_rf_pulses: %0d, want %0d", rf_cnt - rf0, exp_rf);
        end
    endtask

    task automatic test_branch();
        run_instr(ADDI, 1'b1, 1'b1, 32'h8000_0100, 0, 0);
        run_instr(ADDI, 1'b1, 1'b1, 32'h8000_0102, 0, 0);
        test_stopped(1'b0, 2'd2);
    endtask

    task automatic test_timeout();
        int n;
        do_reset(1);
        n = 0;
        while (imem_if.imem_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        imem_if.imem_req_ready = 1'b1;
        step();
        imem_if.imem_req_ready = 1'b0;
        repeat (255) step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b after 255 wait cycles, want 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL timeout: err=%b code=%0d, want 1/1", err, err_code);
        end
        test_stopped(1'b0, 2'd1);
        do_reset(1);
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0 || pc !== RST_PC || inst !== 32'd0 ||
            instret !== 32'd0 || imem_if.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_err: err=%b code=%0d pc=%h inst=%h instret=%0d valid=%b",
                     err, err_code, pc, inst, instret, imem_if.imem_req_valid);
        end
        run_instr(ADDI, 1'b1, 1'b0, 32'd0, 0, 2);
    endtask

    task automatic test_ebreak();
        run_instr(EBRK, 1'b1, 1'b0, 32'd0, 1, 1);
        test_stopped(1'b1, 2'd0);
    endtask

    task automatic test_reset_in_wait();
        int n;
        do_reset(1);
        n = 0;
        while (imem_if.imem_req_valid !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        imem_if.imem_req_ready = 1'b1;
        step();
        imem_if.imem_req_ready = 1'b0;
        step();
        rst = 1'b0;
        imem_if.imem_resp_valid = 1'b1;
        imem_if.imem_resp_inst  = 32'h1234_5678;
        step();
        rst = 1'b1;
        imem_if.imem_resp_inst  = 32'h0BAD_F00D;
        #1;
        checks++;
        if (pc !== RST_PC || inst !== 32'd0 || imem_if.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: pc=%h inst=%h valid=%b, want %h/0/0",
                     pc, inst, imem_if.imem_req_valid, RST_PC);
        end
        step();
        checks++;
        if (inst !== 32'd0 || imem_if.imem_req_valid !== 1'b1 || imem_if.imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL restart_req: inst=%h valid=%b addr=%h, want 0/1/%h",
                     inst, imem_if.imem_req_valid, imem_if.imem_req_addr, RST_PC);
        end
        step();
        imem_if.imem_resp_valid = 1'b0;
        checks++;
        if (inst !== 32'd0 || imem_if.imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_resp_ignored: inst=%h valid=%b, want 0/1", inst, imem_if.imem_req_valid);
        end
        m_pc      = RST_PC;
        m_instret = 32'd0;
        run_instr(ADDI, 1'b1, 1'b0, 32'd0, 0, 0);
        run_instr(ADDI, 1'b1, 1'b1, 32'h8000_0040, 2, 3);
    endtask

    initial begin
        imem_if.imem_req_ready  = 1'b0;
        imem_if.imem_resp_valid = 1'b0;
        imem_if.imem_resp_inst  = 32'd0;
        test_reset();
        test_three_addi();
        test_ready_stall();
        test_wrap();
        test_random();
        test_branch();
        test_timeout();
        test_ebreak();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_npc_ctrl_fsm
`default_nettype wire

// File: doc/npc_ctrl_fsm.md
Name: npc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the NPC core. It owns the PC and fetches instructions over a valid/ready instruction-memory handshake.
- It latches each instruction into an IR that drives the decoder, ALU and register file, and gates the register-file write to a single EXEC cycle.
- It halts on ebreak and reports fetch timeouts and misaligned redirects.
- It replaces the free-running PC+4 register of the single-cycle core.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- EBREAK_INST, 32'h0010_0073, encoding that halts the core.
- TIMEOUT, 255, max cycles spent in WAIT before error; 8-bit counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address, equal to pc.
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  fetched instruction valid.
- imem_resp_inst  in  32  fetched instruction.
- inst  out  32  IR contents, to the decoder.
- dec_reg_wen  in  1  decoder register-write request for the current IR.
- rf_wen  out  1  gated register-file write enable.
- br_taken  in  1  redirect request, sampled in EXEC only.
- br_target  in  32  redirect address.
- pc  out  32  current PC.
- halt  out  1  sticky; ebreak retired.
- err  out  1  sticky; error stop.
- err_code  out  2  0 = none, 1 = fetch timeout, 2 = misaligned target.
- instret  out  32  count of retired instructions; wraps.

Behaviour:
- Reset values (rst==0 at a clk edge):
  - state = IDLE, pc = RESET_PC, inst = 0.
  - imem_req_valid = 0, rf_wen = 0.
  - halt = 0, err = 0, err_code = 0, instret = 0, timeout counter = 0.
- Reset wins over every other event in the same cycle, including mid-fetch. Any in-flight response is dropped.
- The memory side shares rst, so no stale response may arrive after reset.
- States and transitions:
  - IDLE: one cycle, then FETCH. Provides one post-reset bubble.
  - FETCH: imem_req_valid = 1, imem_req_addr = pc.
    - On req_valid && req_ready -> WAIT, with the timeout counter cleared.
    - req_valid stays high and addr stays stable until accepted.
  - WAIT: req_valid = 0.
    - On resp_valid: IR <= resp_inst, -> EXEC.
    - Otherwise the counter increments. When counter == TIMEOUT with no resp_valid -> ERR, err_code = 1.
  - EXEC: exactly one cycle.
    - rf_wen = dec_reg_wen; rf_wen is 0 in every other state.
    - If inst == EBREAK_INST: -> HALT, rf_wen = 0, pc unchanged, instret += 1.
    - Else if br_taken && br_target[1:0] != 0: -> ERR, err_code = 2, rf_wen = 0, pc and instret unchanged.
    - Else: pc <= br_taken ? br_target : pc + 4 (mod 2^32), instret += 1, -> FETCH.
  - HALT: halt = 1. All outputs are frozen and rf_wen = 0. Exit only by reset.
  - ERR: err = 1. Same freeze as HALT. Exit only by reset.
- Timing and sequencing:
  - imem_resp_valid outside WAIT is ignored. A response is never accepted in the same cycle as its request; the earliest accept is the next cycle.
  - Minimum latency is 3 cycles per instruction (FETCH, WAIT, EXEC) with ready = 1 and a 1-cycle response. The first request is asserted 1 cycle after reset deasserts.
  - inst holds the IR from the WAIT→EXEC edge until the next accepted response, so the decoder is stable through EXEC.
  - pc changes only at the EXEC→FETCH edge.
- Wrap-around:
  - pc + 4 from 32'hFFFF_FFFC gives 0; this is not an error.
  - instret wraps from 32'hFFFF_FFFF to 0.

Decomposition:
- Shared package npc_pkg holds:
  - state enum (IDLE, FETCH, WAIT, EXEC, HALT, ERR);
  - err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_MISALIGN);
  - EBREAK encoding constant;
  - RESET_PC default.
- One sub-module: npc_fetch_timer, the 8-bit WAIT timeout counter with clear, enable and expire outputs.
- The ebreak DPI call moves to the core top and is keyed on halt rising.

Test Plan:
- Reset then 3 addi instructions; ready = 1, resp 1 cycle later:
  - req_addr sequence is 8000_0000, 8000_0004, 8000_0008, 3 cycles apart;
  - rf_wen pulses once per instruction;
  - instret = 3.
- req_ready held 0 for 5 cycles:
  - req_valid and addr stay stable;
  - WAIT is entered on the 6th cycle;
  - pc and instret are unchanged.
- EXEC with br_taken = 1, br_target = 8000_0100: next req_addr = 8000_0100. With br_target = 8000_0102: err = 1, err_code = 2, rf_wen = 0, no further requests.
- IR = 0010_0073: halt = 1, instret incremented, pc frozen, rf_wen = 0. Later resp_valid pulses are ignored until reset.
- resp_valid withheld 256 cycles in WAIT: err = 1, err_code = 1. rst = 0 for one cycle then clears all outputs to reset values, and the fetch restarts at 8000_0000.
- rst = 0 asserted in WAIT and released: first request is 1 cycle later at RESET_PC. A resp_valid pulse during that IDLE/FETCH window does not load the IR.
